// File: rtl/id_ex_decoder.sv
// Decode/issue stage: turns 16-bit instruction words into the registered ID/EX
// bundle (ALU control vector, operand fields, memory strobes) and owns the carry flag.
module id_ex_decoder #(
    parameter int OPW = 5,
    parameter int RAW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_valid,
    input  logic [15:0]    if_instr,
    output logic           if_ready,
    input  logic           ex_ready,
    input  logic           flush,
    input  logic           alu_cout_valid,
    input  logic           alu_cout,
    output logic           idex_valid,
    output logic           ALU_EN,
    output logic [0:13]    ALU_ctrl,
    output logic           rns_en,
    output logic [RAW-1:0] rd_addr,
    output logic [RAW-1:0] rs1_addr,
    output logic [RAW-1:0] rs2_addr,
    output logic [7:0]     imm8,
    output logic           rd_we,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           illegal_op
);

    localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_ADC  = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(3);
    localparam logic [OPW-1:0] OP_CMP  = OPW'(4);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6);
    localparam logic [OPW-1:0] OP_LAND = OPW'(7);
    localparam logic [OPW-1:0] OP_LOR  = OPW'(8);
    localparam logic [OPW-1:0] OP_LNOT = OPW'(9);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(10);
    localparam logic [OPW-1:0] OP_LD   = OPW'(11);
    localparam logic [OPW-1:0] OP_ST   = OPW'(12);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(13);
    localparam logic [OPW-1:0] OP_RNS0 = OPW'(16);
    localparam logic [OPW-1:0] OP_RNS1 = OPW'(17);
    localparam logic [OPW-1:0] OP_RNS2 = OPW'(18);
    localparam logic [OPW-1:0] OP_RNS3 = OPW'(19);

    localparam int C_ADD   = 0;
    localparam int C_OR    = 1;
    localparam int C_NOT   = 2;
    localparam int C_ANDBW = 3;
    localparam int C_ORBW  = 4;
    localparam int C_AND   = 6;
    localparam int C_CIN   = 7;
    localparam int C_COMPL = 8;
    localparam int C_JMP   = 9;
    localparam int C_CMP   = 10;
    localparam int C_SHL   = 11;
    localparam int C_LGCL  = 12;
    localparam int C_STORE = 13;

    typedef struct packed {
        logic           valid;
        logic           alu_en;
        logic [0:13]    ctrl;
        logic           rns_en;
        logic [RAW-1:0] rd;
        logic [RAW-1:0] rs1;
        logic [RAW-1:0] rs2;
        logic [7:0]     imm;
        logic           rd_we;
        logic           mem_rd;
        logic           mem_wr;
        logic           is_ld;
        logic           wr_carry;
    } idex_t;

    idex_t          dec;
    idex_t          idex_d;
    idex_t          idex_q;
    logic [OPW-1:0] opcode;
    logic           use_rs1;
    logic           use_rs2;
    logic           dec_illegal;
    logic           carry_now;
    logic           load_use;
    logic           carry_haz;
    logic           accept;
    logic           illegal_d;
    logic           illegal_q;
    logic           c_flag_d;
    logic           c_flag_q;

    assign opcode = if_instr[15:11];

    // An ADC decoded while the ALU reports a carry takes that carry directly.
    assign carry_now = alu_cout_valid ? alu_cout : c_flag_q;

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        dec         = '0;
        dec.valid   = 1'b1;
        dec.alu_en  = 1'b1;
        dec.rd      = if_instr[10:8];
        dec.rs1     = if_instr[7:5];
        dec.rs2     = if_instr[4:2];
        dec.imm     = if_instr[7:0];
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        dec_illegal = 1'b0;
        case (opcode)
            OP_NOP: begin
                dec.alu_en = 1'b0;
                use_rs1    = 1'b0;
                use_rs2    = 1'b0;
            end
            OP_ADD: begin
                dec.ctrl[C_ADD] = 1'b1;
                dec.rd_we       = 1'b1;
                dec.wr_carry    = 1'b1;
            end
            OP_ADC: begin
                dec.ctrl[C_ADD] = 1'b1;
                dec.ctrl[C_CIN] = carry_now;
                dec.rd_we       = 1'b1;
                dec.wr_carry    = 1'b1;
            end
            OP_SUB: begin
                dec.ctrl[C_ADD]   = 1'b1;
                dec.ctrl[C_COMPL] = 1'b1;
                dec.ctrl[C_CIN]   = 1'b1;
                dec.rd_we         = 1'b1;
                dec.wr_carry      = 1'b1;
            end
            OP_CMP: begin
                dec.ctrl[C_CMP]   = 1'b1;
                dec.ctrl[C_COMPL] = 1'b1;
                dec.ctrl[C_CIN]   = 1'b1;
            end
            OP_AND: begin
                dec.ctrl[C_ANDBW] = 1'b1;
                dec.ctrl[C_LGCL]  = 1'b1;
                dec.rd_we         = 1'b1;
            end
            OP_OR: begin
                dec.ctrl[C_ORBW] = 1'b1;
                dec.ctrl[C_LGCL] = 1'b1;
                dec.rd_we        = 1'b1;
            end
            OP_LAND: begin
                dec.ctrl[C_AND]  = 1'b1;
                dec.ctrl[C_LGCL] = 1'b1;
                dec.rd_we        = 1'b1;
            end
            OP_LOR: begin
                dec.ctrl[C_OR]   = 1'b1;
                dec.ctrl[C_LGCL] = 1'b1;
                dec.rd_we        = 1'b1;
            end
            OP_LNOT: begin
                dec.ctrl[C_NOT]  = 1'b1;
                dec.ctrl[C_LGCL] = 1'b1;
                dec.rd_we        = 1'b1;
                use_rs2          = 1'b0;
            end
            OP_SHL: begin
                dec.ctrl[C_SHL] = 1'b1;
                dec.rd_we       = 1'b1;
                dec.wr_carry    = 1'b1;
                use_rs2         = 1'b0;
            end
            OP_LD: begin
                dec.ctrl[C_ADD]   = 1'b1;
                dec.ctrl[C_STORE] = 1'b1;
                dec.mem_rd        = 1'b1;
                dec.rd_we         = 1'b1;
                dec.is_ld         = 1'b1;
            end
            OP_ST: begin
                dec.ctrl[C_ADD]   = 1'b1;
                dec.ctrl[C_STORE] = 1'b1;
                dec.mem_wr        = 1'b1;
            end
            OP_JMP: begin
                dec.ctrl[C_JMP] = 1'b1;
                dec.alu_en      = 1'b0;
                use_rs1         = 1'b0;
                use_rs2         = 1'b0;
            end
            OP_RNS0, OP_RNS1, OP_RNS2, OP_RNS3: begin
                dec.alu_en = 1'b0;
                dec.rns_en = 1'b1;
                dec.rd_we  = 1'b1;
            end
            default: begin
                dec.alu_en  = 1'b0;
                use_rs1     = 1'b0;
                use_rs2     = 1'b0;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // A held load blocks any reader of its destination; a held carry writer blocks ADC
    // until it leaves, so the ADC sees the fresh carry.
    assign load_use  = idex_q.valid && idex_q.is_ld &&
                       ((use_rs1 && (idex_q.rd == if_instr[7:5])) ||
                        (use_rs2 && (idex_q.rd == if_instr[4:2])));
    assign carry_haz = idex_q.valid && idex_q.wr_carry && (opcode == OP_ADC);

    assign if_ready  = !(load_use || carry_haz) && !flush && (ex_ready || !idex_q.valid);
    assign accept    = if_valid && if_ready;

    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (accept) begin
            idex_d = dec;
        end else if (ex_ready || !idex_q.valid) begin
            idex_d = '0;
        end
    end

    assign illegal_d = accept && dec_illegal;
    assign c_flag_d  = carry_now;

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q    <= '0;
            illegal_q <= 1'b0;
            c_flag_q  <= 1'b0;
        end else begin
            idex_q    <= idex_d;
            illegal_q <= illegal_d;
            c_flag_q  <= c_flag_d;
        end
    end

    assign idex_valid = idex_q.valid;
    assign ALU_EN     = idex_q.alu_en;
    assign ALU_ctrl   = idex_q.ctrl;
    assign rns_en     = idex_q.rns_en;
    assign rd_addr    = idex_q.rd;
    assign rs1_addr   = idex_q.rs1;
    assign rs2_addr   = idex_q.rs2;
    assign imm8       = idex_q.imm;
    assign rd_we      = idex_q.rd_we;
    assign mem_rd     = idex_q.mem_rd;
    assign mem_wr     = idex_q.mem_wr;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_id_ex_decoder.sv
// Self-checking bench for id_ex_decoder: decode table through a scoreboard,
// plus directed stall, bubble, hold, flush, carry-bypass and reset sequences.
module tb_id_ex_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        if_ready;
    logic        ex_ready;
    logic        flush;
    logic        alu_cout_valid;
    logic        alu_cout;
    logic        idex_valid;
    logic        ALU_EN;
    logic [0:13] ALU_ctrl;
    logic        rns_en;
    logic [2:0]  rd_addr;
    logic [2:0]  rs1_addr;
    logic [2:0]  rs2_addr;
    logic [7:0]  imm8;
    logic        rd_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal_op;

    id_ex_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_ready       (if_ready),
        .ex_ready       (ex_ready),
        .flush          (flush),
        .alu_cout_valid (alu_cout_valid),
        .alu_cout       (alu_cout),
        .idex_valid     (idex_valid),
        .ALU_EN         (ALU_EN),
        .ALU_ctrl       (ALU_ctrl),
        .rns_en         (rns_en),
        .rd_addr        (rd_addr),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .imm8           (imm8),
        .rd_we          (rd_we),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .illegal_op     (illegal_op)
    );

    always #5 clk = ~clk;

    localparam int ADD_OP = 0, OR_OP = 1, NOT_OP = 2, AND_BW = 3, OR_BW = 4;
    localparam int AND_OP = 6, CIN = 7, ENC = 8, JMP_T = 9, CMP_T = 10;
    localparam int SHL_T = 11, LGCL = 12, STORE = 13;

    typedef struct {
        logic [15:0] instr;
        logic [36:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [36:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    logic [36:0] obs;
    assign obs = {ALU_EN, ALU_ctrl, rns_en, rd_addr, rs1_addr, rs2_addr, imm8,
                  rd_we, mem_rd, mem_wr, illegal_op};

    task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [0:13] cb(input int a, input int b, input int c);
        logic [0:13] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
        return {op[4:0], rd[2:0], rs1[2:0], rs2[2:0], 2'b00};
    endfunction

    function automatic logic [36:0] mk(input logic [15:0] i, input logic alu, input logic [0:13] c,
                                       input logic rns, input logic we, input logic mr,
                                       input logic mw, input logic ill);
        return {alu, c, rns, i[10:8], i[7:5], i[4:2], i[7:0], we, mr, mw, ill};
    endfunction

    function automatic void add_vec(input int op, input int rd, input int rs1, input int rs2,
                                    input logic alu, input logic [0:13] c, input logic rns,
                                    input logic we, input logic mr, input logic mw, input logic ill);
        vec_t v;
        v.instr = enc(op, rd, rs1, rs2);
        v.exp   = mk(v.instr, alu, c, rns, we, mr, mw, ill);
        tbl.push_back(v);
    endfunction

    // Scoreboard side: an instruction leaves ID/EX when it is valid and EX takes it.
    always @(negedge clk) begin
        if (!rst && idex_valid && ex_ready) begin
            if (sb.size() == 0) check("sb_dup", {39'b0, idex_valid}, 40'd0);
            else check("sb", {3'b0, obs}, {3'b0, sb.pop_front()});
        end
    end

    task automatic send(input logic [15:0] instr, input logic [36:0] exp);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        if_valid = 1'b1;
        if_instr = instr;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = if_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (acc) sb.push_back(exp);
        else check("send_timeout", {39'b0, if_ready}, 40'd1);
        if_valid = 1'b0;
    endtask

    // Held op is consumed, incoming op waits exactly one cycle, then issues.
    task automatic stall_one(input string nm, input logic [15:0] instr, input logic [36:0] exp,
                             input logic cv, input logic co);
        if_valid = 1'b1;
        if_instr = instr;
        alu_cout_valid = cv;
        alu_cout = co;
        @(negedge clk);
        check({nm, "_stall"}, {39'b0, if_ready}, 40'd0);
        @(posedge clk);
        #1;
        alu_cout_valid = 1'b0;
        alu_cout = 1'b0;
        @(negedge clk);
        check({nm, "_bubble"}, {39'b0, idex_valid}, 40'd0);
        check({nm, "_ready"}, {39'b0, if_ready}, 40'd1);
        @(posedge clk);
        sb.push_back(exp);
        #1;
        if_valid = 1'b0;
        @(negedge clk);
        check({nm, "_issue"}, {39'b0, idex_valid}, 40'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] i_sub, i_ld, i_and, i_or, i_lor, i_add, i_adc, i_jmp, i_nop, i_ill;
        logic [36:0] e_or;

        add_vec(0,  0, 0, 0, 1'b0, cb(-1, -1, -1),         1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1,  1, 2, 3, 1'b1, cb(ADD_OP, -1, -1),     1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(2,  2, 3, 4, 1'b1, cb(ADD_OP, -1, -1),     1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(3,  3, 4, 5, 1'b1, cb(ADD_OP, CIN, ENC),   1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(4,  0, 6, 7, 1'b1, cb(CMP_T, CIN, ENC),    1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(5,  4, 1, 2, 1'b1, cb(AND_BW, LGCL, -1),   1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(6,  5, 2, 3, 1'b1, cb(OR_BW, LGCL, -1),    1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(7,  6, 3, 4, 1'b1, cb(AND_OP, LGCL, -1),   1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(8,  7, 4, 5, 1'b1, cb(OR_OP, LGCL, -1),    1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(9,  1, 5, 0, 1'b1, cb(NOT_OP, LGCL, -1),   1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(10, 2, 6, 0, 1'b1, cb(SHL_T, -1, -1),      1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(11, 3, 7, 1, 1'b1, cb(ADD_OP, STORE, -1),  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add_vec(12, 0, 3, 2, 1'b1, cb(ADD_OP, STORE, -1),  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add_vec(13, 0, 5, 1, 1'b0, cb(JMP_T, -1, -1),      1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(16, 1, 2, 3, 1'b0, cb(-1, -1, -1),         1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(19, 4, 5, 6, 1'b0, cb(-1, -1, -1),         1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(14, 0, 1, 2, 1'b0, cb(-1, -1, -1),         1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec(31, 7, 7, 7, 1'b0, cb(-1, -1, -1),         1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        i_sub = enc(3, 1, 2, 3);
        i_ld  = enc(11, 4, 1, 0);
        i_and = enc(5, 5, 4, 2);
        i_or  = enc(6, 2, 3, 1);
        i_lor = enc(8, 6, 1, 7);
        i_add = enc(1, 1, 2, 3);
        i_adc = enc(2, 3, 1, 2);
        i_jmp = enc(13, 0, 5, 1);
        i_nop = enc(0, 0, 0, 0);
        i_ill = enc(31, 2, 4, 6);

        // Reset held with a valid instruction presented.
        rst = 1'b1;
        if_valid = 1'b1;
        if_instr = i_add;
        ex_ready = 1'b1;
        flush = 1'b0;
        alu_cout_valid = 1'b0;
        alu_cout = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", {39'b0, idex_valid}, 40'd0);
        check("rst_ctrl", {26'b0, ALU_ctrl}, 40'd0);
        check("rst_out", {3'b0, obs}, 40'd0);
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {39'b0, if_ready}, 40'd1);
        check("rst_idle", {39'b0, idex_valid}, 40'd0);
        @(posedge clk);
        #1;

        // Decode table, carry flag still clear.
        for (int k = 0; k < tbl.size(); k++) send(tbl[k].instr, tbl[k].exp);

        // SUB r1,r2,r3: one-cycle latency.
        send(i_sub, mk(i_sub, 1'b1, cb(ADD_OP, CIN, ENC), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        check("sub_valid", {39'b0, idex_valid}, 40'd1);
        check("sub_alu_en", {39'b0, ALU_EN}, 40'd1);
        @(posedge clk);
        #1;

        // Load-use: LD r4 <- r1, then AND r5,r4,r2.
        send(i_ld, mk(i_ld, 1'b1, cb(ADD_OP, STORE, -1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        stall_one("ldu", i_and, mk(i_and, 1'b1, cb(AND_BW, LGCL, -1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0),
                  1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Hold an OR for three cycles with the next op waiting.
        e_or = mk(i_or, 1'b1, cb(OR_BW, LGCL, -1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(i_or, e_or);
        ex_ready = 1'b0;
        if_valid = 1'b1;
        if_instr = i_lor;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_out", {3'b0, obs}, {3'b0, e_or});
            check("hold_ready", {39'b0, if_ready}, 40'd0);
            @(posedge clk);
            #1;
        end
        ex_ready = 1'b1;
        send(i_lor, mk(i_lor, 1'b1, cb(OR_OP, LGCL, -1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

        // ADD then ADC: carry from ADD's EX cycle reaches the stalled ADC.
        send(i_add, mk(i_add, 1'b1, cb(ADD_OP, -1, -1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        stall_one("carry", i_adc, mk(i_adc, 1'b1, cb(ADD_OP, CIN, -1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0),
                  1'b1, 1'b1);
        check("carry_cin", {39'b0, ALU_ctrl[CIN]}, 40'd1);
        @(posedge clk);
        #1;

        // Flush while a JMP is held: incoming ADD is dropped, carry flag kept.
        send(i_jmp, mk(i_jmp, 1'b0, cb(JMP_T, -1, -1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        flush = 1'b1;
        if_valid = 1'b1;
        if_instr = i_add;
        @(negedge clk);
        check("flush_ready", {39'b0, if_ready}, 40'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        if_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", {39'b0, idex_valid}, 40'd0);
        check("flush_out", {3'b0, obs}, 40'd0);
        @(posedge clk);
        #1;
        send(i_adc, mk(i_adc, 1'b1, cb(ADD_OP, CIN, -1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

        // Carry bypass: flag is 1, ALU reports 0 in the ADC's decode cycle.
        send(i_nop, mk(i_nop, 1'b0, cb(-1, -1, -1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if_valid = 1'b1;
        if_instr = i_adc;
        alu_cout_valid = 1'b1;
        alu_cout = 1'b0;
        @(negedge clk);
        check("byp_ready", {39'b0, if_ready}, 40'd1);
        @(posedge clk);
        sb.push_back(mk(i_adc, 1'b1, cb(ADD_OP, -1, -1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        #1;
        if_valid = 1'b0;
        alu_cout_valid = 1'b0;

        // Undefined opcode 11111: one-cycle illegal flag.
        send(i_ill, mk(i_ill, 1'b0, cb(-1, -1, -1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        check("ill_flag", {39'b0, illegal_op}, 40'd1);
        check("ill_en", {37'b0, ALU_EN, rns_en, rd_we}, 40'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ill_pulse", {39'b0, illegal_op}, 40'd0);
        @(posedge clk);
        #1;

        // Reset while an instruction is held discards it.
        ex_ready = 1'b0;
        send(i_add, mk(i_add, 1'b1, cb(ADD_OP, -1, -1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check("rstmid_valid", {39'b0, idex_valid}, 40'd0);
        check("rstmid_out", {3'b0, obs}, 40'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ex_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("sb_drain", 40'(sb.size()), 40'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
